paddle_io_capture: RTL

Memory-mapped input-capture peripheral that sits between the video/paddle signals and the FEMTO-8 CPU data bus, in place of the bare combinational IN_HPOS/IN_VPOS/IN_FLAGS decode. It latches paddle positions once per frame, accumulates sprite collisions over a frame and exposes them double-buffered, counts frames, and holds sticky event flags that the CPU clears by writing. The top level ORs its `sel` into the read mux ahead of RAM/ROM.

---
 rtl/paddle_io_capture.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/paddle_io_capture.sv
// paddle_io_capture: memory-mapped input capture for the FEMTO-8 bus.
// Latches paddle positions once per frame, accumulates sprite collisions
// into a per-frame latch, counts frames and keeps sticky W1C status bits.
// Optional build macro: PADDLE_IO_SYNC_EN adds 2-flop paddle synchronizers.
module paddle_io_capture #(
    parameter logic [7:0] BASE = 8'h40
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [8:0] hpos,
    input  logic [8:0] vpos,
    input  logic       display_on,
    input  logic       hsync,
    input  logic       vsync,
    input  logic       hpaddle,
    input  logic       vpaddle,
    input  logic       player_gfx,
    input  logic       enemy_gfx,
    input  logic       track_gfx,
    input  logic [7:0] address,
    input  logic [7:0] data_in,
    input  logic       write,
    output logic [7:0] data_out,
    output logic       sel
);

    logic       vsync_q;
    logic       fe;
    logic       hp_c, vp_c;
    logic       hp_q, vp_q;
    logic       h_edge, v_edge;
    logic       h_cap, v_cap;
    logic       h_armed, v_armed;
    logic [7:0] paddle_x, paddle_y;
    logic [7:0] frame_cnt;
    logic [4:0] status;
    logic       acc_pe, acc_pt;
    logic       coll_pe, coll_pt;
    logic       hit_pe, hit_pt;
    logic       new_pe, new_pt;
    logic [7:0] vpos_sat;
    logic [4:0] status_set, status_clr;
    logic [7:0] rd;

`ifdef PADDLE_IO_SYNC_EN
    logic hp_s1, hp_s2, vp_s1, vp_s2;

    // two-flop synchronizers on the raw paddle comparators
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hp_s1 <= 1'b0;
            hp_s2 <= 1'b0;
            vp_s1 <= 1'b0;
            vp_s2 <= 1'b0;
        end else begin
            hp_s1 <= hpaddle;
            hp_s2 <= hp_s1;
            vp_s1 <= vpaddle;
            vp_s2 <= vp_s1;
        end
    end

    assign hp_c = hp_s2;
    assign vp_c = vp_s2;
`else
    assign hp_c = hpaddle;
    assign vp_c = vpaddle;
`endif

    assign fe       = vsync & ~vsync_q;
    assign h_edge   = hp_c & ~hp_q;
    assign v_edge   = vp_c & ~vp_q;
    // an edge coinciding with the frame event counts for the new frame
    assign h_cap    = h_edge & (h_armed | fe);
    assign v_cap    = v_edge & (v_armed | fe);
    assign vpos_sat = vpos[8] ? 8'hFF : vpos[7:0];
    assign hit_pe   = display_on & player_gfx & enemy_gfx;
    assign hit_pt   = display_on & player_gfx & track_gfx;
    assign new_pe   = acc_pe | hit_pe;
    assign new_pt   = acc_pt | hit_pt;
    assign sel      = (address[7:3] == BASE[7:3]);

    assign status_set = {fe, fe & new_pt, fe & new_pe, v_cap, h_cap};
    assign status_clr = (write && sel && address[2:0] == 3'd6) ? data_in[4:0] : '0;

    // edge-detect delay flops for vsync and the conditioned paddles
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vsync_q <= 1'b0;
            hp_q    <= 1'b0;
            vp_q    <= 1'b0;
        end else begin
            vsync_q <= vsync;
            hp_q    <= hp_c;
            vp_q    <= vp_c;
        end
    end

    // once-per-frame paddle position capture, re-armed at each frame event
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_armed  <= 1'b1;
            v_armed  <= 1'b1;
            paddle_x <= '0;
            paddle_y <= '0;
        end else begin
            if (h_cap) begin
                paddle_x <= vpos_sat;
                h_armed  <= 1'b0;
            end else if (fe) begin
                h_armed  <= 1'b1;
            end
            if (v_cap) begin
                paddle_y <= vpos_sat;
                v_armed  <= 1'b0;
            end else if (fe) begin
                v_armed  <= 1'b1;
            end
        end
    end

    // collision accumulation, frame latch and frame counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_pe    <= 1'b0;
            acc_pt    <= 1'b0;
            coll_pe   <= 1'b0;
            coll_pt   <= 1'b0;
            frame_cnt <= '0;
        end else if (fe) begin
            coll_pe   <= new_pe;
            coll_pt   <= new_pt;
            acc_pe    <= 1'b0;
            acc_pt    <= 1'b0;
            frame_cnt <= frame_cnt + 8'd1;
        end else begin
            acc_pe    <= new_pe;
            acc_pt    <= new_pt;
        end
    end

    // sticky status: a set in the same cycle as a W1C clear wins
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            status <= '0;
        end else begin
            status <= (status & ~status_clr) | status_set;
        end
    end

    // zero-latency register read mux
    always_comb begin
        rd = '0;
        case (address[2:0])
            3'd0: rd = hpos[7:0];
            3'd1: rd = vpos[7:0];
            3'd2: rd = {2'b00, coll_pe | coll_pt, vsync, hsync, vp_c, hp_c, display_on};
            3'd3: rd = paddle_x;
            3'd4: rd = paddle_y;
            3'd5: rd = frame_cnt;
            3'd6: rd = {3'b000, status};
            3'd7: rd = {4'b0000, coll_pt, coll_pe, 2'b00};
            default: rd = '0;
        endcase
    end

    // hpos[8] is outside the byte-wide view and deliberately dropped
    assign data_out = sel ? (rd | {7'b0, hpos[8] & 1'b0}) : '0;

endmodule
